// File: rtl/bresp_mux_2to1_pkg.sv
// Shared encodings for the write router return path: AXI BRESP codes and
// the slave port-select value stored per outstanding transaction.
package bresp_mux_2to1_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    typedef enum logic {
        PORT_S1 = 1'b0,
        PORT_S2 = 1'b1
    } port_sel_e;

endpackage

// File: rtl/bresp_mux_2to1_sync_fifo_ptr.sv
// Generic DEPTH x W register FIFO with registered count; the head entry is
// read combinationally. A push into a full FIFO is accepted only alongside a pop.
module sync_fifo_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (!push_ok && pop_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bresp_mux_2to1.sv
// B-channel return path of the 1-master / 2-slave write router: tracks AW
// handshakes in order and steers the head slave's response to the master.
module bresp_mux_2to1
    import bresp_mux_2to1_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [ID_W-1:0]        awid_m,
    input  logic                   awvalid_s1,
    input  logic                   awready_s1,
    input  logic                   awvalid_s2,
    input  logic                   awready_s2,
    output logic                   aw_full,
    input  logic [ID_W-1:0]        bid_s1,
    input  logic [1:0]             bresp_s1,
    input  logic                   bvalid_s1,
    output logic                   bready_s1,
    input  logic [ID_W-1:0]        bid_s2,
    input  logic [1:0]             bresp_s2,
    input  logic                   bvalid_s2,
    output logic                   bready_s2,
    output logic [ID_W-1:0]        bid_m,
    output logic [1:0]             bresp_m,
    output logic                   bvalid_m,
    input  logic                   bready_m,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err
);

    localparam int unsigned EW = 1 + ID_W;

    logic                   aw_fire1;
    logic                   aw_fire2;
    logic                   push;
    logic                   pop;
    port_sel_e              push_port;
    logic [EW-1:0]          push_entry;
    logic [EW-1:0]          head_entry;
    port_sel_e              head_port;
    logic [ID_W-1:0]        head_id;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] count;
    logic                   err_evt;

    assign aw_fire1   = awvalid_s1 & awready_s1;
    assign aw_fire2   = awvalid_s2 & awready_s2;
    assign push       = aw_fire1 | aw_fire2;
    // Slave 1 wins a same-cycle double handshake; the anomaly is flagged below.
    assign push_port  = aw_fire1 ? PORT_S1 : PORT_S2;
    assign push_entry = {push_port, awid_m};

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_track (
        .clk       (aclk),
        .rst_n     (areset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign head_port   = port_sel_e'(head_entry[EW-1]);
    assign head_id     = head_entry[ID_W-1:0];
    assign aw_full     = fifo_full;
    assign outstanding = count;

    always_comb begin
        bvalid_m  = 1'b0;
        bid_m     = '0;
        bresp_m   = '0;
        bready_s1 = 1'b0;
        bready_s2 = 1'b0;
        if (!fifo_empty) begin
            if (head_port == PORT_S1) begin
                bvalid_m  = bvalid_s1;
                bid_m     = bid_s1;
                bresp_m   = bresp_s1;
                bready_s1 = bready_m;
            end else begin
                bvalid_m  = bvalid_s2;
                bid_m     = bid_s2;
                bresp_m   = bresp_s2;
                bready_s2 = bready_m;
            end
        end
    end

    assign pop = bvalid_m & bready_m;

    always_comb begin
        err_evt = 1'b0;
        if (aw_fire1 && aw_fire2)                   err_evt = 1'b1;
        if (push && fifo_full && !pop)              err_evt = 1'b1;
        if (fifo_empty && (bvalid_s1 || bvalid_s2)) err_evt = 1'b1;
        if (pop && (bid_m != head_id))              err_evt = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!areset)      err <= 1'b0;
        else if (err_evt) err <= 1'b1;
    end

endmodule

// File: tb/tb_bresp_mux_2to1.sv
// Randomized and directed bench: the driver books every accepted AW into a
// scoreboard queue; an independent monitor checks routing, counts and errors.
module tb_bresp_mux_2to1;
    import bresp_mux_2to1_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ID_W  = 4;

    typedef struct {
        bit              port;
        logic [ID_W-1:0] id;
        logic [ID_W-1:0] rid;
        logic [1:0]      resp;
    } exp_t;

    typedef struct {
        logic [ID_W-1:0] rid;
        logic [1:0]      resp;
    } sresp_t;

    logic                   aclk;
    logic                   areset;
    logic [ID_W-1:0]        awid_m;
    logic [1:0]             awv;
    logic [1:0]             awr;
    logic [1:0]             bv;
    logic [ID_W-1:0]        bidv [2];
    logic [1:0]             brv  [2];
    logic                   bready_m;
    logic                   aw_full;
    logic                   br_s1;
    logic                   br_s2;
    logic [ID_W-1:0]        bid_m;
    logic [1:0]             bresp_m;
    logic                   bvalid_m;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   err;

    exp_t   exp_q [$];
    exp_t   pend  [$];
    sresp_t sq0   [$];
    sresp_t sq1   [$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    bresp_mux_2to1 #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .awid_m      (awid_m),
        .awvalid_s1  (awv[0]),
        .awready_s1  (awr[0]),
        .awvalid_s2  (awv[1]),
        .awready_s2  (awr[1]),
        .aw_full     (aw_full),
        .bid_s1      (bidv[0]),
        .bresp_s1    (brv[0]),
        .bvalid_s1   (bv[0]),
        .bready_s1   (br_s1),
        .bid_s2      (bidv[1]),
        .bresp_s2    (brv[1]),
        .bvalid_s2   (bv[1]),
        .bready_s2   (br_s2),
        .bid_m       (bid_m),
        .bresp_m     (bresp_m),
        .bvalid_m    (bvalid_m),
        .bready_m    (bready_m),
        .outstanding (outstanding),
        .err         (err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // One bus cycle: slaves complete/offer responses, master readiness, optional AW.
    task automatic step(input bit do_aw, input bit port, input logic [ID_W-1:0] id,
                        input logic [ID_W-1:0] rid, input logic [1:0] resp, input bit both,
                        input bit track, input bit rdy, input bit en0, input bit en1);
        bit hs0;
        bit hs1;
        exp_t e;
        @(negedge aclk);
        hs0 = bv[0] && br_s1;
        hs1 = bv[1] && br_s2;
        @(posedge aclk);
        #1;
        while (pend.size() > 0) begin
            e = pend.pop_front();
            if (e.port) sq1.push_back('{e.rid, e.resp});
            else        sq0.push_back('{e.rid, e.resp});
        end
        if (hs0) begin
            bv[0] = 1'b0;
            if (sq0.size() > 0) void'(sq0.pop_front());
        end
        if (hs1) begin
            bv[1] = 1'b0;
            if (sq1.size() > 0) void'(sq1.pop_front());
        end
        if (!bv[0] && en0 && sq0.size() > 0) begin
            bv[0] = 1'b1; bidv[0] = sq0[0].rid; brv[0] = sq0[0].resp;
        end
        if (!bv[1] && en1 && sq1.size() > 0) begin
            bv[1] = 1'b1; bidv[1] = sq1[0].rid; brv[1] = sq1[0].resp;
        end
        bready_m = rdy;
        awv      = 2'b00;
        awr      = 2'b00;
        awid_m   = id;
        if (do_aw) begin
            if (both) begin
                awv = 2'b11; awr = 2'b11;
            end else begin
                awv[port] = 1'b1; awr[port] = 1'b1;
            end
            if (track) begin
                e = '{port, id, rid, resp};
                exp_q.push_back(e);
                pend.push_back(e);
            end
        end
    endtask

    task automatic idle(input bit rdy, input bit en0, input bit en1);
        step(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, rdy, en0, en1);
    endtask

    task automatic aw_tr(input bit port, input logic [ID_W-1:0] id,
                         input logic [ID_W-1:0] rid, input logic [1:0] resp);
        step(1'b1, port, id, rid, resp, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() > 0 || sq0.size() > 0 || sq1.size() > 0 || pend.size() > 0) && n < 200) begin
            idle(1'b1, 1'b1, 1'b1);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        areset   = 1'b0;
        awv      = 2'b00;
        awr      = 2'b00;
        bv       = 2'b00;
        bready_m = 1'b0;
        awid_m   = '0;
        pend.delete();
        sq0.delete();
        sq1.delete();
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b1;
    endtask

    // Monitor: model state reflects all edges before this negedge.
    initial begin : monitor
        int unsigned exp_count;
        bit exp_err;
        bit hp;
        bit e_pop;
        bit f0;
        bit f1;
        exp_t e;
        exp_count = 0;
        exp_err   = 1'b0;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                exp_count = 0;
                exp_err   = 1'b0;
                exp_q.delete();
            end else begin
                chk("outstanding", outstanding, exp_count);
                chk("aw_full", aw_full, exp_count == DEPTH);
                chk("err", err, exp_err);
                hp    = 1'b0;
                e_pop = 1'b0;
                if (exp_count == 0) begin
                    chk("empty_bvalid_m", bvalid_m, 0);
                    chk("empty_bready", {br_s1, br_s2}, 0);
                    chk("empty_bid_bresp", {bid_m, bresp_m}, 0);
                end else begin
                    hp    = exp_q[0].port;
                    e_pop = bv[hp] && bready_m;
                    chk("head_bvalid_m", bvalid_m, bv[hp]);
                    chk("sel_bready", hp ? br_s2 : br_s1, bready_m);
                    chk("blocked_bready", hp ? br_s1 : br_s2, 0);
                end
                chk("pop_vs_model", bvalid_m && bready_m, e_pop);
                f0 = awv[0] && awr[0];
                f1 = awv[1] && awr[1];
                if (f0 && f1) exp_err = 1'b1;
                if ((f0 || f1) && exp_count == DEPTH && !e_pop) exp_err = 1'b1;
                if (exp_count == 0 && (bv[0] || bv[1])) exp_err = 1'b1;
                if (e_pop && bidv[hp] != exp_q[0].id) exp_err = 1'b1;
                if (bvalid_m && bready_m && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("bid_m", bid_m, e.rid);
                    chk("bresp_m", bresp_m, e.resp);
                end
                if ((f0 || f1) && (exp_count < DEPTH || e_pop)) exp_count++;
                if (e_pop) exp_count--;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : driver
        bit              da;
        logic [ID_W-1:0] rid;
        areset = 1'b0;
        bidv[0] = '0; bidv[1] = '0;
        brv[0]  = '0; brv[1]  = '0;
        do_reset();

        // single write to slave 1
        aw_tr(1'b0, 4'd3, 4'd3, RESP_OKAY);
        idle(1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        drain();

        // ordering: s2 first, s1 responds early and must wait
        aw_tr(1'b1, 4'd1, 4'd1, RESP_OKAY);
        aw_tr(1'b0, 4'd2, 4'd2, RESP_SLVERR);
        repeat (3) idle(1'b1, 1'b1, 1'b0);
        drain();

        // backpressure from master
        aw_tr(1'b0, 4'd7, 4'd7, RESP_EXOKAY);
        repeat (5) idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        drain();

        // wrap: count 2 with wr_ptr 3, push and pop together
        do_reset();
        aw_tr(1'b0, 4'h1, 4'h1, RESP_OKAY);
        aw_tr(1'b1, 4'h2, 4'h2, RESP_EXOKAY);
        aw_tr(1'b0, 4'h3, 4'h3, RESP_SLVERR);
        idle(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 4'hd, 4'hd, RESP_DECERR, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drain();

        // randomized traffic, protocol-clean
        for (int i = 0; i < 400; i++) begin
            da  = ($urandom_range(0, 1) == 1) && (exp_q.size() < DEPTH);
            rid = ID_W'($urandom);
            step(da, 1'($urandom), rid, rid, 2'($urandom), 1'b0, 1'b1,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end
        drain();

        // unsolicited response while empty
        do_reset();
        idle(1'b0, 1'b0, 1'b0);
        bv[1] = 1'b1; bidv[1] = 4'd4; brv[1] = RESP_OKAY;
        idle(1'b0, 1'b0, 1'b0);
        bv[1] = 1'b0;
        idle(1'b0, 1'b0, 1'b0);

        // BID mismatch: expected 5, slave returns 6
        do_reset();
        aw_tr(1'b0, 4'd5, 4'd6, RESP_OKAY);
        drain();
        idle(1'b0, 1'b0, 1'b0);

        // both slaves handshake in one cycle
        do_reset();
        step(1'b1, 1'b0, 4'd9, 4'd9, RESP_OKAY, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        idle(1'b0, 1'b0, 1'b0);

        // fill, overflow, drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rid = ID_W'($urandom);
            aw_tr(1'($urandom), rid, rid, 2'($urandom));
        end
        step(1'b1, 1'b0, 4'd8, 4'd8, RESP_OKAY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        drain();
        idle(1'b0, 1'b0, 1'b0);

        // reset with three writes in flight and err set
        for (int i = 0; i < 3; i++) aw_tr(1'(i), 4'(i + 10), 4'(i + 10), RESP_OKAY);
        idle(1'b0, 1'b0, 1'b0);
        do_reset();
        idle(1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
